decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Second pipeline stage, directly downstream of the fetch stage. Consumes InstrD/PCD from the fetch/decode register and decodes the 20-bit instruction into control signals. Reads operands from an internal 16-entry register file, which the writeback stage writes. Sign-extends immediates and captures everything in the decode/execute pipeline register, with stall and flush (bubble) control.

Parameters:
DATA_W, 32, register/operand width
PC_W, 15, program counter width (matches fetch stage)
NREGS, 16, register count; r0 reads as zero, writes ignored

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
InstrD  in  20  instruction from fetch/decode register
PCD  in  PC_W  PC of InstrD
StallE  in  1  hold decode/execute register
FlushE  in  1  load bubble into decode/execute register (branch taken)
RegWriteW  in  1  writeback enable
RdW  in  4  writeback destination
ResultW  in  DATA_W  writeback data
RD1E, RD2E  out  DATA_W  registered operands
ImmExtE  out  DATA_W  registered sign-extended immediate
PCE  out  PC_W  registered PC
Rs1E, Rs2E, RdE  out  4  registered register indices (for hazard unit)
RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, BranchNeE, JumpE  out  1  registered control
ALUControlE  out  3  registered ALU op
IllegalE  out  1  registered reserved-opcode flag

Behaviour:
- Formats:
  - R: op[19:16] rd[15:12] rs1[11:8] rs2[7:4]
  - I/LW: op rd rs1 imm8[7:0]
  - SW: op rs2[15:12] rs1[11:8] imm8
  - BEQ/BNE: op rs1[15:12] rs2[11:8] off8[7:0]
  - JMP: op off16[15:0]
- Opcodes (0x0–0xF):
  - 0 NOP: all control 0
  - 1–7 ADD, SUB, AND, OR, XOR, SLL, SRL: ALUControl = op−1, RegWrite
  - 8 ADDI: ALUControl 0, ALUSrc, RegWrite
  - 9 LW: ALUSrc, RegWrite, ResultSrc
  - A SW: ALUSrc, MemWrite
  - B BEQ: Branch, ALUControl 1
  - C BNE: Branch, BranchNe, ALUControl 1
  - D JMP: Jump
  - E/F reserved: all control 0, IllegalE=1
- Immediate: imm8/off8/off16 sign-extended to DATA_W. R-type ImmExt = 0.
- Unused index fields decode to 0; e.g. Rs2 = 0 for I-type.
- Register file read is combinational in the decode cycle. Index 0 returns 0.
- Register file write:
  - on posedge when RegWriteW=1 and RdW≠0
  - RdW=0 writes are dropped
- Same-cycle read/write of the same register without WB_BYPASS_EN: the old value is read and the new value is visible next cycle.
- Decode/execute register update on posedge, in priority order:
  - FlushE=1: all control outputs, IllegalE, RdE/Rs1E/Rs2E, RD1E/RD2E, ImmExtE, PCE ← 0 (bubble)
  - else StallE=1: hold all outputs
  - else: load decoded values
- FlushE beats StallE.
- Latency: one cycle from InstrD/PCD to *E outputs.
- Reset (reset=0, asynchronous):
  - all outputs 0
  - all registers cleared to 0
  - WB writes ignored while reset is asserted
- Reset deassertion mid-stream: first edge loads InstrD normally.

Optional Feature:
WB_BYPASS_EN:
- When defined: if RegWriteW=1, RdW≠0 and RdW equals the rs1 or rs2 index being read, that read returns ResultW in the same cycle (write-through).
- When undefined: old value is returned; the hazard unit must stall one extra cycle.

Decomposition:
- Package decode_pkg:
  - opcode enum (OP_NOP..OP_JMP)
  - ALU op constants
  - field bit positions
  - packed struct ctrl_t for the control bundle
- Sub-module regfile_16x (combinational read ports, clocked write, r0 zero, bypass under WB_BYPASS_EN) is natural.
- Decoder and pipeline register stay in decode_stage.

Test Plan:
- Reset: hold reset=0 and apply WB writes → all outputs 0. After release, ADD r1,r0,r0 → RD1E=0, RegWriteE=1, ALUControlE=0, RdE=1.
- Writeback then read: RegWriteW=1 RdW=3 ResultW=0x1234, next cycle InstrD=ADDI r4,r3,0xFF (0x843FF) → RD1E=0x1234, ImmExtE=0xFFFFFFFF, ALUSrcE=1.
- Same-cycle write/read of r3=0xABCD with ADD r5,r3,r3 → RD1E=RD2E=0xABCD with WB_BYPASS_EN, previous value without.
- r0 write: RdW=0 ResultW=0xFFFF, then read r0 → 0.
- Stall/flush: StallE=1 two cycles → outputs held. StallE=1 with FlushE=1 → bubble, all control 0, PCE=0.
- Decode sweep:
  - SW (0xA21F0) → MemWriteE=1, Rs2E=2, Rs1E=1, ImmExtE=0xFFFFFFF0
  - BNE → BranchE=BranchNeE=1
  - JMP 0x8000 → JumpE=1, ImmExtE=0xFFFF8000
  - op 0xE → IllegalE=1, other control 0

Source files
------------

// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : Shared types and constants for the decode stage: opcode
//               enumeration, ALU operation codes, instruction field
//               positions and the packed control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam int C_NREGS = 16;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_SLL   = 4'h6,
        OP_SRL   = 4'h7,
        OP_ADDI  = 4'h8,
        OP_LW    = 4'h9,
        OP_SW    = 4'hA,
        OP_BEQ   = 4'hB,
        OP_BNE   = 4'hC,
        OP_JMP   = 4'hD,
        OP_RSV_E = 4'hE,
        OP_RSV_F = 4'hF
    } opcode_e;

    localparam logic [2:0] C_ALU_ADD = 3'd0;
    localparam logic [2:0] C_ALU_SUB = 3'd1;
    localparam logic [2:0] C_ALU_AND = 3'd2;
    localparam logic [2:0] C_ALU_OR  = 3'd3;
    localparam logic [2:0] C_ALU_XOR = 3'd4;
    localparam logic [2:0] C_ALU_SLL = 3'd5;
    localparam logic [2:0] C_ALU_SRL = 3'd6;

    // Top bit of each 4-bit field and of the immediates in the 20-bit word
    localparam int C_OP_HI    = 19;
    localparam int C_F1_HI    = 15;
    localparam int C_F2_HI    = 11;
    localparam int C_F3_HI    = 7;
    localparam int C_IMM8_HI  = 7;
    localparam int C_IMM16_HI = 15;

    typedef struct packed {
        logic       reg_write;
        logic       result_src;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       illegal;
        logic [2:0] alu_control;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/decode_stage_if.sv
// ============================================================================
// Module      : decode_stage_if
// Description : Bundle of fetch, hazard, writeback inputs and decode/execute
//               register outputs of the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 15
);
    logic [19:0]       InstrD;
    logic [PC_W-1:0]   PCD;
    logic              StallE;
    logic              FlushE;
    logic              RegWriteW;
    logic [3:0]        RdW;
    logic [DATA_W-1:0] ResultW;

    logic [DATA_W-1:0] RD1E;
    logic [DATA_W-1:0] RD2E;
    logic [DATA_W-1:0] ImmExtE;
    logic [PC_W-1:0]   PCE;
    logic [3:0]        Rs1E;
    logic [3:0]        Rs2E;
    logic [3:0]        RdE;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              ResultSrcE;
    logic              ALUSrcE;
    logic              BranchE;
    logic              BranchNeE;
    logic              JumpE;
    logic [2:0]        ALUControlE;
    logic              IllegalE;

    modport slave (
        input  InstrD, PCD, StallE, FlushE, RegWriteW, RdW, ResultW,
        output RD1E, RD2E, ImmExtE, PCE, Rs1E, Rs2E, RdE,
               RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE,
               BranchNeE, JumpE, ALUControlE, IllegalE
    );

    modport master (
        output InstrD, PCD, StallE, FlushE, RegWriteW, RdW, ResultW,
        input  RD1E, RD2E, ImmExtE, PCE, Rs1E, Rs2E, RdE,
               RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE,
               BranchNeE, JumpE, ALUControlE, IllegalE
    );
endinterface

`default_nettype wire

// File: rtl/regfile_16x.sv
// ============================================================================
// Module      : regfile_16x
// Description : 16-entry register file, two combinational read ports, one
//               clocked write port. r0 reads as zero and ignores writes.
//               Optional macro WB_BYPASS_EN: a write to the register being
//               read is forwarded to the read port in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_16x
    import decode_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [3:0]        i_ra1,
    input  wire logic [3:0]        i_ra2,
    output logic      [DATA_W-1:0] o_rd1,
    output logic      [DATA_W-1:0] o_rd2,
    input  wire logic              i_we,
    input  wire logic [3:0]        i_wa,
    input  wire logic [DATA_W-1:0] i_wd
);

    logic [DATA_W-1:0] mem_q [C_NREGS];
    logic [DATA_W-1:0] mem_d [C_NREGS];

    // Next register contents: only a non-zero destination is updated
    always_comb begin
        mem_d = mem_q;
        if (i_we && (i_wa != 4'd0)) begin
            mem_d[i_wa] = i_wd;
        end
    end

    // Register storage, cleared by the asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < C_NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read ports: stored value, optional write-through, r0 forced to zero
    always_comb begin
        o_rd1 = mem_q[i_ra1];
        o_rd2 = mem_q[i_ra2];
`ifdef WB_BYPASS_EN
        if (i_we && (i_wa != 4'd0) && (i_wa == i_ra1)) o_rd1 = i_wd;
        if (i_we && (i_wa != 4'd0) && (i_wa == i_ra2)) o_rd2 = i_wd;
`endif
        if (i_ra1 == 4'd0) o_rd1 = '0;
        if (i_ra2 == 4'd0) o_rd2 = '0;
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : Pipeline decode stage. Decodes the 20-bit instruction, reads
//               operands from the register file, sign-extends immediates and
//               captures the result in the decode/execute register with
//               flush (bubble) priority over stall.
//               Optional macro WB_BYPASS_EN enables writeback write-through
//               in the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 15
) (
    input  wire logic     clk,
    input  wire logic     reset,
    decode_stage_if.slave bus
);

    opcode_e           w_op;
    ctrl_t             w_ctrl;
    logic [3:0]        w_rs1;
    logic [3:0]        w_rs2;
    logic [3:0]        w_rd;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_imm8_ext;
    logic [DATA_W-1:0] w_imm16_ext;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [3:0]        w_f1;
    logic [3:0]        w_f2;
    logic [3:0]        w_f3;

    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [3:0]        rs1_q, rs1_d;
    logic [3:0]        rs2_q, rs2_d;
    logic [3:0]        rd_q, rd_d;

    assign w_op        = opcode_e'(bus.InstrD[C_OP_HI -: 4]);
    assign w_f1        = bus.InstrD[C_F1_HI -: 4];
    assign w_f2        = bus.InstrD[C_F2_HI -: 4];
    assign w_f3        = bus.InstrD[C_F3_HI -: 4];
    assign w_imm8_ext  = {{(DATA_W-8){bus.InstrD[C_IMM8_HI]}},   bus.InstrD[C_IMM8_HI:0]};
    assign w_imm16_ext = {{(DATA_W-16){bus.InstrD[C_IMM16_HI]}}, bus.InstrD[C_IMM16_HI:0]};

    // Instruction decoder: control bundle, register indices and immediate
    always_comb begin
        w_ctrl = '0;
        w_rs1  = 4'd0;
        w_rs2  = 4'd0;
        w_rd   = 4'd0;
        w_imm  = '0;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_control = 3'(w_op - 4'd1);
                w_rd  = w_f1;
                w_rs1 = w_f2;
                w_rs2 = w_f3;
            end
            OP_ADDI, OP_LW: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src     = 1'b1;
                w_ctrl.result_src  = (w_op == OP_LW);
                w_ctrl.alu_control = C_ALU_ADD;
                w_rd  = w_f1;
                w_rs1 = w_f2;
                w_imm = w_imm8_ext;
            end
            OP_SW: begin
                w_ctrl.mem_write   = 1'b1;
                w_ctrl.alu_src     = 1'b1;
                w_ctrl.alu_control = C_ALU_ADD;
                w_rs2 = w_f1;
                w_rs1 = w_f2;
                w_imm = w_imm8_ext;
            end
            OP_BEQ, OP_BNE: begin
                w_ctrl.branch      = 1'b1;
                w_ctrl.branch_ne   = (w_op == OP_BNE);
                w_ctrl.alu_control = C_ALU_SUB;
                w_rs1 = w_f1;
                w_rs2 = w_f2;
                w_imm = w_imm8_ext;
            end
            OP_JMP: begin
                w_ctrl.jump = 1'b1;
                w_imm       = w_imm16_ext;
            end
            OP_RSV_E, OP_RSV_F: begin
                w_ctrl.illegal = 1'b1;
            end
            default: begin
                w_ctrl = '0;
            end
        endcase
    end

    regfile_16x #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2),
        .i_we  (bus.RegWriteW),
        .i_wa  (bus.RdW),
        .i_wd  (bus.ResultW)
    );

    // Decode/execute register next state: flush beats stall beats load
    always_comb begin
        ctrl_d = ctrl_q;
        rd1_d  = rd1_q;
        rd2_d  = rd2_q;
        imm_d  = imm_q;
        pc_d   = pc_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        rd_d   = rd_q;
        if (bus.FlushE) begin
            ctrl_d = '0;
            rd1_d  = '0;
            rd2_d  = '0;
            imm_d  = '0;
            pc_d   = '0;
            rs1_d  = 4'd0;
            rs2_d  = 4'd0;
            rd_d   = 4'd0;
        end else if (!bus.StallE) begin
            ctrl_d = w_ctrl;
            rd1_d  = w_rd1;
            rd2_d  = w_rd2;
            imm_d  = w_imm;
            pc_d   = bus.PCD;
            rs1_d  = w_rs1;
            rs2_d  = w_rs2;
            rd_d   = w_rd;
        end
    end

    // Decode/execute register storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            pc_q   <= '0;
            rs1_q  <= 4'd0;
            rs2_q  <= 4'd0;
            rd_q   <= 4'd0;
        end else begin
            ctrl_q <= ctrl_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            imm_q  <= imm_d;
            pc_q   <= pc_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            rd_q   <= rd_d;
        end
    end

    assign bus.RD1E        = rd1_q;
    assign bus.RD2E        = rd2_q;
    assign bus.ImmExtE     = imm_q;
    assign bus.PCE         = pc_q;
    assign bus.Rs1E        = rs1_q;
    assign bus.Rs2E        = rs2_q;
    assign bus.RdE         = rd_q;
    assign bus.RegWriteE   = ctrl_q.reg_write;
    assign bus.MemWriteE   = ctrl_q.mem_write;
    assign bus.ResultSrcE  = ctrl_q.result_src;
    assign bus.ALUSrcE     = ctrl_q.alu_src;
    assign bus.BranchE     = ctrl_q.branch;
    assign bus.BranchNeE   = ctrl_q.branch_ne;
    assign bus.JumpE       = ctrl_q.jump;
    assign bus.ALUControlE = ctrl_q.alu_control;
    assign bus.IllegalE    = ctrl_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed, table-driven self-checking bench for decode_stage.
//               Expected operand for the same-cycle write/read row depends
//               on WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

    localparam int DATA_W = 32;
    localparam int PC_W   = 15;
    localparam int NVEC   = 20;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] C_SAME_CYCLE_R3 = 32'h0000ABCD;
`else
    localparam logic [31:0] C_SAME_CYCLE_R3 = 32'h00001234;
`endif

    // ctrl byte: {RegWrite, ResultSrc, MemWrite, ALUSrc, Branch, BranchNe, Jump, Illegal}
    typedef struct {
        logic [19:0] instr;
        logic [14:0] pc;
        logic        wb_en;
        logic [3:0]  wb_rd;
        logic [31:0] wb_data;
        logic        stall;
        logic        flush;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_imm;
        logic [14:0] e_pc;
        logic [3:0]  e_rs1;
        logic [3:0]  e_rs2;
        logic [3:0]  e_rd;
        logic [7:0]  e_ctrl;
        logic [2:0]  e_alu;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    vec_t vecs [NVEC];

    decode_stage_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

    decode_stage #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic [19:0] instr, input logic [14:0] pc,
        input logic wb_en, input logic [3:0] wb_rd, input logic [31:0] wb_data,
        input logic stall, input logic flush,
        input logic [31:0] e_rd1, input logic [31:0] e_rd2, input logic [31:0] e_imm,
        input logic [14:0] e_pc, input logic [3:0] e_rs1, input logic [3:0] e_rs2,
        input logic [3:0] e_rd, input logic [7:0] e_ctrl, input logic [2:0] e_alu);
        vec_t v;
        v.instr = instr;  v.pc = pc;  v.wb_en = wb_en;  v.wb_rd = wb_rd;
        v.wb_data = wb_data;  v.stall = stall;  v.flush = flush;
        v.e_rd1 = e_rd1;  v.e_rd2 = e_rd2;  v.e_imm = e_imm;  v.e_pc = e_pc;
        v.e_rs1 = e_rs1;  v.e_rs2 = e_rs2;  v.e_rd = e_rd;
        v.e_ctrl = e_ctrl;  v.e_alu = e_alu;
        return v;
    endfunction

    task automatic chk(input string name, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [step %0d]: actual %h required %h", name, tag, act, exp);
        end
    endtask

    task automatic chk_outputs(input int tag, input vec_t v);
        logic [7:0] ctrl;
        ctrl = {bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.ALUSrcE,
                bus.BranchE, bus.BranchNeE, bus.JumpE, bus.IllegalE};
        chk("RD1E",        tag, bus.RD1E,            v.e_rd1);
        chk("RD2E",        tag, bus.RD2E,            v.e_rd2);
        chk("ImmExtE",     tag, bus.ImmExtE,         v.e_imm);
        chk("PCE",         tag, 32'(bus.PCE),        32'(v.e_pc));
        chk("Rs1E",        tag, 32'(bus.Rs1E),       32'(v.e_rs1));
        chk("Rs2E",        tag, 32'(bus.Rs2E),       32'(v.e_rs2));
        chk("RdE",         tag, 32'(bus.RdE),        32'(v.e_rd));
        chk("ctrl",        tag, 32'(ctrl),           32'(v.e_ctrl));
        chk("ALUControlE", tag, 32'(bus.ALUControlE), 32'(v.e_alu));
    endtask

    task automatic drive(input vec_t v);
        bus.InstrD    = v.instr;
        bus.PCD       = v.pc;
        bus.RegWriteW = v.wb_en;
        bus.RdW       = v.wb_rd;
        bus.ResultW   = v.wb_data;
        bus.StallE    = v.stall;
        bus.FlushE    = v.flush;
    endtask

    initial begin
        vec_t zero_v;
        vec_t v;
        n_checks = 0;
        n_errors = 0;
        zero_v = mk(20'h0, 15'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0,
                    32'h0, 32'h0, 32'h0, 15'h0, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0);

        //        instr     pc        wb rd    data          st    fl    rd1           rd2           imm           epc       rs1   rs2   rd    ctrl   alu
        vecs[0]  = mk(20'h11000, 15'h010, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        15'h010, 4'h0, 4'h0, 4'h1, 8'h80, 3'd0);
        vecs[1]  = mk(20'h12110, 15'h011, 1'b1, 4'h3, 32'h1234,   1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        15'h011, 4'h1, 4'h1, 4'h2, 8'h80, 3'd0);
        vecs[2]  = mk(20'h843FF, 15'h012, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'h1234,     32'h0,        32'hFFFFFFFF, 15'h012, 4'h3, 4'h0, 4'h4, 8'h90, 3'd0);
        vecs[3]  = mk(20'h15330, 15'h013, 1'b1, 4'h3, 32'hABCD,   1'b0, 1'b0, C_SAME_CYCLE_R3, C_SAME_CYCLE_R3, 32'h0,  15'h013, 4'h3, 4'h3, 4'h5, 8'h80, 3'd0);
        vecs[4]  = mk(20'h16300, 15'h014, 1'b1, 4'h0, 32'hFFFF,   1'b0, 1'b0, 32'hABCD,     32'h0,        32'h0,        15'h014, 4'h3, 4'h0, 4'h6, 8'h80, 3'd0);
        vecs[5]  = mk(20'h17030, 15'h015, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'h0,        32'hABCD,     32'h0,        15'h015, 4'h0, 4'h3, 4'h7, 8'h80, 3'd0);
        vecs[6]  = mk(20'hA21F0, 15'h016, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFF0, 15'h016, 4'h1, 4'h2, 4'h0, 8'h30, 3'd0);
        vecs[7]  = mk(20'h98305, 15'h017, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'hABCD,     32'h0,        32'h5,        15'h017, 4'h3, 4'h0, 4'h8, 8'hD0, 3'd0);
        vecs[8]  = mk(20'hB30FE, 15'h018, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'hABCD,     32'h0,        32'hFFFFFFFE, 15'h018, 4'h3, 4'h0, 4'h0, 8'h08, 3'd1);
        vecs[9]  = mk(20'hC3310, 15'h019, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'hABCD,     32'hABCD,     32'h10,       15'h019, 4'h3, 4'h3, 4'h0, 8'h0C, 3'd1);
        vecs[10] = mk(20'hD8000, 15'h01A, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFF8000, 15'h01A, 4'h0, 4'h0, 4'h0, 8'h02, 3'd0);
        vecs[11] = mk(20'hE1234, 15'h01B, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        15'h01B, 4'h0, 4'h0, 4'h0, 8'h01, 3'd0);
        vecs[12] = mk(20'h79340, 15'h01C, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'hABCD,     32'h0,        32'h0,        15'h01C, 4'h3, 4'h4, 4'h9, 8'h80, 3'd6);
        vecs[13] = mk(20'h2A330, 15'h01D, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'hABCD,     32'hABCD,     32'h0,        15'h01D, 4'h3, 4'h3, 4'hA, 8'h80, 3'd1);
        vecs[14] = mk(20'h00000, 15'h01E, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        15'h01E, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0);
        vecs[15] = mk(20'h5B330, 15'h100, 1'b0, 4'h0, 32'h0,      1'b0, 1'b0, 32'hABCD,     32'hABCD,     32'h0,        15'h100, 4'h3, 4'h3, 4'hB, 8'h80, 3'd4);
        vecs[16] = mk(20'h11000, 15'h200, 1'b0, 4'h0, 32'h0,      1'b1, 1'b0, 32'hABCD,     32'hABCD,     32'h0,        15'h100, 4'h3, 4'h3, 4'hB, 8'h80, 3'd4);
        vecs[17] = mk(20'h11000, 15'h201, 1'b0, 4'h0, 32'h0,      1'b1, 1'b0, 32'hABCD,     32'hABCD,     32'h0,        15'h100, 4'h3, 4'h3, 4'hB, 8'h80, 3'd4);
        vecs[18] = mk(20'h843FF, 15'h202, 1'b0, 4'h0, 32'h0,      1'b1, 1'b1, 32'h0,        32'h0,        32'h0,        15'h000, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0);
        vecs[19] = mk(20'h3C330, 15'h7FFF, 1'b0, 4'h0, 32'h0,     1'b0, 1'b0, 32'hABCD,     32'hABCD,     32'h0,        15'h7FFF, 4'h3, 4'h3, 4'hC, 8'h80, 3'd2);

        // Reset held with writeback activity: outputs stay zero, writes dropped
        reset = 1'b0;
        v = zero_v;
        v.instr = 20'h11000;  v.pc = 15'h005;
        v.wb_en = 1'b1;  v.wb_rd = 4'h1;  v.wb_data = 32'hDEAD;
        drive(v);
        repeat (2) @(posedge clk);
        #1;
        chk_outputs(100, zero_v);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven sequence; each row is one clock of the stage
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk_outputs(i, vecs[i]);
        end

        // Asynchronous reset mid-stream: outputs clear without a clock edge
        drive(vecs[19]);
        #2;
        reset = 1'b0;
        #1;
        chk_outputs(200, zero_v);

        // Writeback during reset is dropped and the register file is cleared
        v = zero_v;
        v.wb_en = 1'b1;  v.wb_rd = 4'h5;  v.wb_data = 32'h5555;
        drive(v);
        @(posedge clk);
        #1;
        chk_outputs(201, zero_v);
        @(negedge clk);
        reset = 1'b1;

        // First edge after release loads normally: ADD r1,r3,r5 reads zeros
        v = mk(20'h11350, 15'h033, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0,
               32'h0, 32'h0, 32'h0, 15'h033, 4'h3, 4'h5, 4'h1, 8'h80, 3'd0);
        drive(v);
        @(posedge clk);
        #1;
        chk_outputs(202, v);

        // Flush alone after a valid load produces a bubble
        v = zero_v;
        v.instr = 20'hD8000;  v.pc = 15'h044;  v.flush = 1'b1;
        drive(v);
        @(posedge clk);
        #1;
        chk_outputs(203, zero_v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
